// File: rtl/servo_pkg.sv
// Shared types and elaboration-time helpers for the servo pulse decoder.
// Count derivation keeps the same scaling as the servo PWM generator.
package servo_pkg;

  typedef enum logic [1:0] {ST_SYNC, ST_WAIT_RISE, ST_HIGH, ST_STUCK} servo_state_e;

  localparam int                 DUTY_W      = 10;
  localparam longint unsigned    DUTY_MAX    = 1000;
  localparam logic [DUTY_W-1:0]  DUTY_CENTRE = DUTY_W'(500);

  function automatic longint unsigned period_count(longint unsigned freq, longint unsigned hz);
    return freq / hz;
  endfunction

  // Used for the min, max and tolerance counts alike.
  function automatic longint unsigned ns_count(longint unsigned freq, longint unsigned ns);
    return (freq * ns) / 64'd1_000_000_000;
  endfunction

  function automatic int calc_num_w(longint unsigned min_c, longint unsigned max_c);
    return $clog2((max_c - min_c) * DUTY_MAX + 1);
  endfunction

  function automatic int calc_cnt_w(longint unsigned period_c, longint unsigned periods);
    return $clog2(periods * period_c + 1);
  endfunction

endpackage

// File: rtl/servo_pwm_decoder_div.sv
// Sequential restoring unsigned divider, one quotient bit per cycle.
// Only the low QW quotient bits are exported; the caller guarantees they suffice.
module servo_div #(
  parameter int W  = 26,
  parameter int QW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [W-1:0]  i_numerator,
  input  logic [W-1:0]  i_denominator,
  output logic          o_busy,
  output logic          o_done,
  output logic [QW-1:0] o_quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_rem, r_q, r_den;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_done;
  logic [W:0]    w_shift, w_sub;

  always_comb begin
    w_shift = {r_rem, r_q[W-1]};
    w_sub   = w_shift - {1'b0, r_den};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_rem  <= '0;
        r_q    <= i_numerator;
        r_den  <= i_denominator;
        r_cnt  <= CW'(W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        // Borrow out of the trial subtract means the divisor did not fit.
        if (w_sub[W]) begin
          r_rem <= w_shift[W-1:0];
          r_q   <= {r_q[W-2:0], 1'b0};
        end else begin
          r_rem <= w_sub[W-1:0];
          r_q   <= {r_q[W-2:0], 1'b1};
        end
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_q[QW-1:0];

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo pulse high time and maps 1.0-2.0 ms back to duty 0..1000.
// Flags out-of-range / stuck pulses and loss of the pulse train.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter longint unsigned INPUT_FREQ      = 50_000_000,
  parameter longint unsigned REFRESH_HZ      = 50,
  parameter longint unsigned MIN_PULSE_NS    = 1_000_000,
  parameter longint unsigned MAX_PULSE_NS    = 2_000_000,
  parameter longint unsigned TOL_NS          = 100_000,
  parameter int              FILTER_LEN      = 4,
  parameter longint unsigned TIMEOUT_PERIODS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_level,
  output logic              duty_valid,
  output logic              pulse_err,
  output logic              signal_lost
);

  localparam longint unsigned PERIOD_L = period_count(INPUT_FREQ, REFRESH_HZ);
  localparam longint unsigned MIN_L    = ns_count(INPUT_FREQ, MIN_PULSE_NS);
  localparam longint unsigned MAX_L    = ns_count(INPUT_FREQ, MAX_PULSE_NS);
  localparam longint unsigned TOL_L    = ns_count(INPUT_FREQ, TOL_NS);
  localparam longint unsigned TO_L     = TIMEOUT_PERIODS * PERIOD_L;

  localparam int NUM_W = calc_num_w(MIN_L, MAX_L);
  localparam int CNT_W = calc_cnt_w(PERIOD_L, TIMEOUT_PERIODS);
  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_L);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_L);
  localparam logic [CNT_W-1:0] LO_C     = CNT_W'(MIN_L - TOL_L);
  localparam logic [CNT_W-1:0] STUCK_C  = CNT_W'(MAX_L + TOL_L + 1);
  localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TO_L);
  localparam logic [CNT_W-1:0] TO_M1_C  = CNT_W'(TO_L - 1);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(FILTER_LEN + 2);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [NUM_W-1:0] DEN_C    = NUM_W'(MAX_L - MIN_L);
  localparam logic [NUM_W-1:0] SCALE_C  = NUM_W'(DUTY_MAX);

  logic [1:0]        r_sync;
  logic              r_filt, r_filt_d;
  logic [FLT_W-1:0]  r_flt_cnt;
  logic [CNT_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0]  r_hc;
  servo_state_e      r_state;
  logic              r_err;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid, r_lost;

  logic              w_rise, w_to_hit, w_fall, w_short, w_start;
  logic [CNT_W-1:0]  w_hc_inc, w_hc_cl;
  logic [NUM_W-1:0]  w_num;
  logic              w_div_busy, w_div_done;
  logic [DUTY_W-1:0] w_quot;

  // Input conditioning and time-since-last-rise counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_filt    <= 1'b0;
      r_filt_d  <= 1'b0;
      r_flt_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_sync   <= {r_sync[0], pwm_in};
      r_filt_d <= r_filt;
      if (r_sync[1] == r_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_LAST) begin
        r_filt    <= r_sync[1];
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + FLT_W'(1);
      end
      if (w_rise)
        r_to_cnt <= CNT_W'(1);
      else if (r_to_cnt != TO_C)
        r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_rise   = r_filt && !r_filt_d;
    w_to_hit = !w_rise && (r_to_cnt == TO_M1_C);
    w_hc_inc = (r_hc == STUCK_C) ? r_hc : r_hc + CNT_W'(1);
    w_fall   = (r_state == ST_HIGH) && !r_filt;
    w_short  = r_hc < LO_C;
    w_start  = w_fall && !w_short && !w_div_busy;
    if (r_hc < MIN_C)      w_hc_cl = MIN_C;
    else if (r_hc > MAX_C) w_hc_cl = MAX_C;
    else                   w_hc_cl = r_hc;
    w_num    = NUM_W'(w_hc_cl - MIN_C) * SCALE_C;
  end

  // In SYNC, r_hc doubles as a settle counter so a pulse already high at
  // reset release is not mistaken for a fresh rise while the synchronizer fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SYNC;
      r_hc    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_SYNC: begin
          if (r_filt || r_sync[1])  r_hc <= '0;
          else if (r_hc == SETTLE_C) r_state <= ST_WAIT_RISE;
          else                       r_hc <= r_hc + CNT_W'(1);
        end
        ST_WAIT_RISE: begin
          if (r_filt) begin
            r_hc    <= CNT_W'(1);
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (r_filt) begin
            r_hc <= w_hc_inc;
            if (w_hc_inc == STUCK_C) begin
              r_err   <= 1'b1;
              r_state <= ST_STUCK;
            end
          end else begin
            r_state <= ST_WAIT_RISE;
            if (w_short || w_div_busy) r_err <= 1'b1;
          end
        end
        ST_STUCK: begin
          if (!r_filt) r_state <= ST_WAIT_RISE;
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  servo_div #(.W(NUM_W), .QW(DUTY_W)) u_div (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (w_start),
    .i_numerator   (w_num),
    .i_denominator (DEN_C),
    .o_busy        (w_div_busy),
    .o_done        (w_div_done),
    .o_quotient    (w_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty  <= DUTY_CENTRE;
      r_valid <= 1'b0;
      r_lost  <= 1'b1;
    end else begin
      r_valid <= w_div_done;
      if (w_div_done) r_duty <= w_quot;
      if (w_to_hit)        r_lost <= 1'b1;
      else if (w_div_done) r_lost <= 1'b0;
    end
  end

  assign duty_level  = r_duty;
  assign duty_valid  = r_valid;
  assign pulse_err   = r_err;
  assign signal_lost = r_lost;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Randomized pulse-train bench for servo_pwm_decoder on a scaled clock
// (500 kHz, 500 Hz refresh) so every scenario fits in a short run.
module tb_servo_pwm_decoder;

  localparam int FREQ     = 500_000;
  localparam int HZ       = 500;
  localparam int MIN_C    = 500;
  localparam int MAX_C    = 1000;
  localparam int TOL_C    = 50;
  localparam int PERIOD_C = FREQ / HZ;
  localparam int TO_C     = 3 * PERIOD_C;
  localparam int NUM_W    = $clog2((MAX_C - MIN_C) * 1000 + 1);
  localparam int IN_DLY   = 2 + 4;
  localparam int LAT      = NUM_W + 2;
  localparam int LO_LIM   = MIN_C - TOL_C;
  localparam int HI_LIM   = MAX_C + TOL_C + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [9:0] duty_level;
  logic       duty_valid, pulse_err, signal_lost;

  always #5 clk = ~clk;

  servo_pwm_decoder #(
    .INPUT_FREQ(FREQ), .REFRESH_HZ(HZ), .MIN_PULSE_NS(1_000_000),
    .MAX_PULSE_NS(2_000_000), .TOL_NS(100_000), .FILTER_LEN(4), .TIMEOUT_PERIODS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .duty_level(duty_level),
    .duty_valid(duty_valid), .pulse_err(pulse_err), .signal_lost(signal_lost)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int q_v_cyc[$], q_v_val[$], q_v_lost[$], q_e_cyc[$], q_l_cyc[$];
  logic prev_lost = 1'b1;
  int exp_duty = 500;
  int last_rise = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (duty_valid) begin
        q_v_cyc.push_back(cyc);
        q_v_val.push_back(int'(duty_level));
        q_v_lost.push_back(int'(signal_lost));
      end
      if (pulse_err) q_e_cyc.push_back(cyc);
      if (signal_lost && !prev_lost) q_l_cyc.push_back(cyc);
    end
    prev_lost <= signal_lost;
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_duty(input int w);
    int c;
    c = (w < MIN_C) ? MIN_C : (w > MAX_C) ? MAX_C : w;
    return (c - MIN_C) * 1000 / (MAX_C - MIN_C);
  endfunction

  task automatic clear_q();
    q_v_cyc.delete(); q_v_val.delete(); q_v_lost.delete();
    q_e_cyc.delete(); q_l_cyc.delete();
  endtask

  task automatic check_pulse(input int w, input int cr, input int cf);
    if (w < LO_LIM) begin
      chk("short_err_n", q_e_cyc.size(), 1);
      if (q_e_cyc.size() > 0) chk("short_err_cyc", q_e_cyc[0], cf + IN_DLY + 1);
      chk("short_valid_n", q_v_cyc.size(), 0);
    end else if (w >= HI_LIM) begin
      chk("stuck_err_n", q_e_cyc.size(), 1);
      if (q_e_cyc.size() > 0) chk("stuck_err_cyc", q_e_cyc[0], cr + IN_DLY + HI_LIM);
      chk("stuck_valid_n", q_v_cyc.size(), 0);
    end else begin
      exp_duty = model_duty(w);
      chk("valid_n", q_v_cyc.size(), 1);
      chk("err_n", q_e_cyc.size(), 0);
      if (q_v_cyc.size() > 0) begin
        chk("valid_cyc", q_v_cyc[0], cf + IN_DLY + LAT);
        chk("valid_duty", q_v_val[0], exp_duty);
        chk("lost_at_valid", q_v_lost[0], 0);
      end
    end
    chk("duty_hold", int'(duty_level), exp_duty);
    chk("lost_rise_n", q_l_cyc.size(), 0);
    clear_q();
  endtask

  // glitch > 0 drops the input low for two cycles at that offset into the pulse.
  task automatic pulse(input int w, input int lo, input int glitch);
    int cr, cf;
    @(negedge clk); pwm_in = 1'b1; cr = cyc;
    for (int i = 1; i < w; i++) begin
      @(negedge clk);
      pwm_in = (glitch > 0 && (i == glitch || i == glitch + 1)) ? 1'b0 : 1'b1;
    end
    @(negedge clk); pwm_in = 1'b0; cf = cyc;
    repeat (lo) @(negedge clk);
    last_rise = cr;
    check_pulse(w, cr, cf);
  endtask

  int dw[12] = '{750, 500, 1000, 525, 1040, 470, 450, 449, 250, 1050, 1051, 2000};

  initial begin
    rst_n = 1'b0; pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty_level), 500);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_err", int'(pulse_err), 0);
    chk("rst_lost", int'(signal_lost), 1);
    rst_n = 1'b1;
    repeat (4 * PERIOD_C) @(negedge clk);
    chk("idle_duty", int'(duty_level), 500);
    chk("idle_lost", int'(signal_lost), 1);
    chk("idle_valid_n", q_v_cyc.size(), 0);
    chk("idle_err_n", q_e_cyc.size(), 0);
    clear_q();

    foreach (dw[i]) pulse(dw[i], 600, 0);
    repeat (15) pulse(int'($urandom_range(400, 1100)), int'($urandom_range(100, 600)), 0);

    // Reset while the divider is mid-flight, with the input high across release.
    @(negedge clk); pwm_in = 1'b1;
    repeat (900) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    clear_q();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_duty", int'(duty_level), 500);
    chk("mid_rst_valid", int'(duty_valid), 0);
    chk("mid_rst_err", int'(pulse_err), 0);
    chk("mid_rst_lost", int'(signal_lost), 1);
    exp_duty = 500;
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (500) @(negedge clk);
    chk("partial_valid_n", q_v_cyc.size(), 0);
    chk("partial_err_n", q_e_cyc.size(), 0);
    chk("partial_duty", int'(duty_level), 500);
    clear_q();
    pulse(900, 400, 0);

    pulse(750, 100, 300);
    while (cyc < last_rise + IN_DLY + TO_C + 20) @(negedge clk);
    chk("timeout_n", q_l_cyc.size(), 1);
    if (q_l_cyc.size() > 0) chk("timeout_cyc", q_l_cyc[0], last_rise + IN_DLY + TO_C);
    chk("timeout_lost", int'(signal_lost), 1);
    chk("timeout_duty", int'(duty_level), exp_duty);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Receives a 50 Hz servo pulse train, either from an external RC receiver or looped back from our own servo PWM output, and measures the high time of each pulse.
- Converts the 1.0–2.0 ms pulse back to a duty_level in 0..1000 using the same scaling as the servo PWM generator, so the two blocks form an encode/decode pair.
- Flags out-of-range pulses and loss of signal.
- Sits between an external pin and the control logic; it is also used for closed-loop self-test of the servo output.

Parameters:
- INPUT_FREQ, 50_000_000: clk frequency in Hz.
- REFRESH_HZ, 50: nominal pulse repetition rate.
- MIN_PULSE_NS, 1_000_000: pulse width that maps to duty 0.
- MAX_PULSE_NS, 2_000_000: pulse width that maps to duty 1000.
- TOL_NS, 100_000: accepted overshoot beyond MIN/MAX; values in that band are clamped.
- FILTER_LEN, 4: consecutive stable cycles required for the filtered level to change.
- TIMEOUT_PERIODS, 3: nominal periods without a rising edge before signal_lost asserts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pwm_in  in  1  asynchronous servo pulse input
- duty_level  out  10  last decoded duty, 0..1000
- duty_valid  out  1  one-cycle strobe when duty_level updates
- pulse_err  out  1  one-cycle strobe on a rejected pulse
- signal_lost  out  1  level; no rising edge seen within the timeout

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). All flops clear immediately on rst_n low.
- Reset values: duty_level=500 (servo centre), duty_valid=0, pulse_err=0, signal_lost=1. Synchronizer and filter clear to 0. FSM goes to SYNC. Any divide in progress is aborted.
- Derived counts: PERIOD_COUNT=INPUT_FREQ/REFRESH_HZ. MIN_COUNT, MAX_COUNT and TOL_COUNT = INPUT_FREQ*x_NS/1e9, with defaults 50000, 100000 and 5000.
- Input path: 2-flop synchronizer, then a stability filter. The filtered level takes the synchronized value only after it has differed for FILTER_LEN consecutive cycles. Both edges see the same delay, so measured width equals input width.
- Width count: hc = number of clk cycles the filtered signal is 1. A 75000-cycle input pulse gives hc=75000.
- FSM SYNC: wait for filtered=0, so a pulse already in progress at reset release is ignored. Then go to WAIT_RISE.
- FSM WAIT_RISE: a filtered rising edge starts hc at 1 and moves to HIGH.
- FSM HIGH, on falling edge, when hc < MIN_COUNT-TOL_COUNT: strobe pulse_err, go to WAIT_RISE.
- FSM HIGH, on falling edge, when hc is in range: clamp hc to [MIN_COUNT, MAX_COUNT], start the divider, go to WAIT_RISE.
- FSM HIGH, stuck high: if hc reaches MAX_COUNT+TOL_COUNT+1 while still high, strobe pulse_err once and go to STUCK. STUCK waits for filtered=0, then goes to WAIT_RISE with no second error.
- Arithmetic: numerator = (hc_clamped-MIN_COUNT)*1000; denominator = MAX_COUNT-MIN_COUNT.
  - Unsigned, quotient truncated, guaranteed ≤1000.
  - NUM_W = clog2(numerator_max+1), which is 26 with defaults.
- Latency: duty_level updates and duty_valid pulses exactly NUM_W+2 cycles after the clk edge on which the filtered falling edge is detected.
- Divider busy: an accepted falling edge while the divider is still busy is dropped and strobes pulse_err. This is unreachable with legal widths.
- Timeout: a counter of cycles since the last filtered rising edge saturates at TIMEOUT_PERIODS*PERIOD_COUNT. signal_lost goes to 1 on the cycle the counter reaches that value. It clears on the cycle duty_valid asserts.
- Holding: duty_level holds its last value through errors and signal loss.
- Counter width: CNT_W = clog2(TIMEOUT_PERIODS*PERIOD_COUNT+1). All counters saturate and never wrap.

Decomposition:
- servo_pkg holds:
  - count-derivation functions (period, min, max, tol counts);
  - NUM_W and CNT_W calculation;
  - FSM state enum {SYNC, WAIT_RISE, HIGH, STUCK}.
- One sub-module, servo_div: a sequential restoring unsigned divider.
  - Interface: start, numerator, denominator, busy, done, quotient.
  - Takes NUM_W cycles from start to done; aborts on rst_n.

Test Plan:
- Reset, pwm_in held low for 4 periods -> duty_level=500, signal_lost=1, no strobes.
- 75000-cycle pulses at a 1,000,000-cycle period -> duty_level=500 and a single duty_valid exactly 28 cycles after the filtered fall; signal_lost drops with that strobe.
- Widths 50000/100000/52500/104000/47000 cycles -> duty 0/1000/50/1000 (clamped)/0 (clamped), with no pulse_err.
- 25000-cycle pulse -> pulse_err at the fall, duty_level unchanged. Held high 200000 cycles -> one pulse_err at hc=105001, none at the later fall.
- 2-cycle low glitch mid-pulse of 75000 -> duty still 500. Then no edges -> signal_lost rises exactly 3,000,000 cycles after the last filtered rise.
- rst_n low mid-pulse -> immediate reset values, divider aborted. The partial pulse after release is ignored (no strobe); the next full pulse decodes correctly.
